i2c_master_ctrl: RTL and testbench

Synchronous single-byte I2C master controller that sequences complete START / address / data / STOP transactions on the same two-wire bus served by the team's receive-side I2C slave block (7-bit address 7'h27 by default on that block). A local requester loads address, direction and write data, pulses `start`, and receives `done`, `ack_err` and read data. The block generates SCL from the system clock and drives SDA open-drain, never high.

---
 rtl/i2c_master_ctrl_if.sv | 24 ++
 rtl/i2c_master_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_if.sv
// Request-side interface of the single-byte I2C master controller.
// The requester uses the master modport. The controller uses the slave
// modport, because it serves requests.
//
// Request handshake: start is a one-cycle request. It is accepted on a rising
// edge only when busy=0, and it is ignored while busy=1 (there is no queuing).
// rw, addr and wdata are latched on the accepting edge. busy rises in the next
// cycle. done pulses for exactly one cycle, in the first cycle after busy falls.
// ack_err and rdata are valid from that done cycle onward.
interface i2c_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    modport master (output start, rw, addr, wdata,
                    input  busy, done, ack_err, rdata);
    modport slave  (input  start, rw, addr, wdata,
                    output busy, done, ack_err, rdata);
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+rw, ACK, one data byte, ACK, STOP.
// SCL is push-pull. SDA is open-drain: it is only ever pulled low or released.
// Optional build macro I2C_MASTER_RETRY_EN: when an address is NACKed, the
// whole frame is retried once before the error is reported.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    i2c_master_ctrl_if.slave    req,
    output logic                scl,
    inout  wire                 sda,
    output logic [2:0]          fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q;
    logic [1:0] q_q;
    logic [2:0] bit_cnt;
    logic [2:0] bit_idx;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q;
    logic [7:0] addr_byte;
    logic [7:0] rx_shift;
    logic [7:0] rdata_q;
    logic       addr_nack;
    logic       ack_err_q;
    logic       done_q;
    logic       accept;
    logic       bit_end;
    logic       sample;
    logic       sda_low;
    logic       sda_in;
`ifdef I2C_MASTER_RETRY_EN
    logic       retried;
`endif

    assign accept    = (state_q == S_IDLE) && req.start;
    assign bit_end   = (state_q != S_IDLE) && (q_q == 2'd3) && (div_q == DIV_LAST);
    assign sample    = (state_q != S_IDLE) && (q_q == 2'd2) && (div_q == DIV_LAST);
    assign bit_idx   = 3'd7 - bit_cnt;
    assign addr_byte = {addr_q, rw_q};
    assign sda_in    = sda;
    assign sda       = sda_low ? 1'b0 : 1'bz;

    assign req.busy    = (state_q != S_IDLE);
    assign req.done    = done_q;
    assign req.ack_err = ack_err_q;
    assign req.rdata   = rdata_q;
    assign fsm_state   = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state sequencing; every state except IDLE lasts whole bit periods.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: if (bit_end) state_d = S_ADDR;
            S_ADDR:  if (bit_end && bit_cnt == 3'd7) state_d = S_AACK;
            S_AACK:  if (bit_end) state_d = addr_nack ? S_STOP : S_DATA;
            S_DATA:  if (bit_end && bit_cnt == 3'd7) state_d = S_DACK;
            S_DACK:  if (bit_end) state_d = S_STOP;
            S_STOP: begin
`ifdef I2C_MASTER_RETRY_EN
                if (bit_end) state_d = (addr_nack && !retried) ? S_START : S_IDLE;
`else
                if (bit_end) state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Quarter-bit timing: the divider wraps every CLK_DIV cycles and advances q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            q_q   <= '0;
        end else if (state_q == S_IDLE) begin
            div_q <= '0;
            q_q   <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            q_q   <= q_q + 2'd1;
        end else begin
            div_q <= div_q + 8'd1;
        end
    end

    // Bit counter within the address and data bytes; it wraps 7 -> 0 between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (accept)
            bit_cnt <= '0;
        else if (bit_end && (state_q == S_ADDR || state_q == S_DATA))
            bit_cnt <= bit_cnt + 3'd1;
    end

    // Request latching, ACK sampling, read shifting and status reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rx_shift  <= '0;
            rdata_q   <= '0;
            addr_nack <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
            retried   <= 1'b0;
`endif
        end else begin
            done_q <= (state_q != S_IDLE) && (state_d == S_IDLE);
            if (accept) begin
                addr_q    <= req.addr;
                rw_q      <= req.rw;
                wdata_q   <= req.wdata;
                addr_nack <= 1'b0;
                ack_err_q <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
                retried   <= 1'b0;
`endif
            end else begin
                if (sample) begin
                    case (state_q)
                        S_AACK: if (sda_in) begin
                            addr_nack <= 1'b1;
`ifdef I2C_MASTER_RETRY_EN
                            if (retried) ack_err_q <= 1'b1;
`else
                            ack_err_q <= 1'b1;
`endif
                        end
                        S_DATA: if (rw_q) rx_shift <= {rx_shift[6:0], sda_in};
                        S_DACK: if (sda_in && !rw_q) ack_err_q <= 1'b1;
                        default: ;
                    endcase
                end
                if (bit_end && state_q == S_DATA && bit_cnt == 3'd7 && rw_q)
                    rdata_q <= rx_shift;
`ifdef I2C_MASTER_RETRY_EN
                if (bit_end && state_q == S_STOP && state_d == S_START) begin
                    retried   <= 1'b1;
                    addr_nack <= 1'b0;
                end
`endif
            end
        end
    end

    // Bus waveform decode: SCL is low in q0-q1 of every bit except START.
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            S_START: sda_low = q_q[1];
            S_ADDR: begin
                scl     = q_q[1];
                sda_low = !addr_byte[bit_idx];
            end
            S_AACK, S_DACK: scl = q_q[1];
            S_DATA: begin
                scl     = q_q[1];
                sda_low = !rw_q && !wdata_q[bit_idx];
            end
            S_STOP: begin
                scl     = q_q[1];
                sda_low = (q_q != 2'd3);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a behavioural I2C slave at 7'h27 on the bus,
// a table of single-byte transactions, and hand sequences for the ignored
// start, the back-to-back start and the mid-frame reset.
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;
    localparam logic [6:0] SLV_ADDR = 7'h27;
`ifdef I2C_MASTER_RETRY_EN
    localparam int RETRY = 1;
`else
    localparam int RETRY = 0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_master_ctrl_if req ();
    logic       scl;
    wire        sda_bus;
    logic [2:0] fsm_state;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .scl       (scl),
        .sda       (sda_bus),
        .fsm_state (fsm_state)
    );

    // behavioural slave (open-drain, pulled up)
    logic       slv_low = 1'b0;
    logic [7:0] slv_rd_data = 8'h00;
    logic       slv_data_nack = 1'b0;
    logic [7:0] slv_abyte = 8'h00;
    logic [7:0] slv_wbyte = 8'h00;
    logic       slv_mack = 1'b0;
    int         rise_cnt = 0;
    int         start_cnt = 0;
    assign sda_bus = slv_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    // Slave protocol tracker, evaluated on the falling system-clock edge.
    initial begin : slave_model
        logic scl_p, sda_p, addressed;
        logic [7:0] shreg;
        int phase, cnt;
        scl_p = 1'b1; sda_p = 1'b1; addressed = 1'b0; shreg = '0; phase = 0; cnt = 0;
        forever begin
            @(negedge clk);
            if (scl && scl_p && sda_p && !sda_bus) begin
                start_cnt = start_cnt + 1;
                phase = 1; cnt = 0; shreg = '0; slv_low = 1'b0; slv_wbyte = 8'h00;
            end else if (scl && scl_p && !sda_p && sda_bus) begin
                phase = 0; slv_low = 1'b0;
            end else if (scl && !scl_p) begin
                rise_cnt = rise_cnt + 1;
                if (phase == 1 || phase == 2) begin
                    if (cnt < 8) shreg = {shreg[6:0], sda_bus};
                    cnt = cnt + 1;
                end else if (phase == 3) begin
                    if (cnt == 8) slv_mack = sda_bus;
                    cnt = cnt + 1;
                end
            end else if (!scl && scl_p) begin
                if (phase == 1) begin
                    if (cnt == 8) begin
                        slv_abyte = shreg;
                        addressed = (shreg[7:1] == SLV_ADDR);
                        slv_low = addressed;
                    end else if (cnt == 9) begin
                        slv_low = 1'b0;
                        cnt = 0;
                        if (!addressed) phase = 0;
                        else if (slv_abyte[0]) begin
                            phase = 3;
                            slv_low = !slv_rd_data[7];
                        end else begin
                            phase = 2;
                            shreg = '0;
                        end
                    end
                end else if (phase == 2) begin
                    if (cnt == 8) begin
                        slv_wbyte = shreg;
                        slv_low = !slv_data_nack;
                    end else if (cnt == 9) begin
                        slv_low = 1'b0;
                        phase = 0;
                    end
                end else if (phase == 3) begin
                    if (cnt < 8) slv_low = !slv_rd_data[7 - cnt];
                    else slv_low = 1'b0;
                end
            end
            scl_p = scl;
            sda_p = sda_bus;
        end
    end

    // scoreboard
    typedef struct packed {
        logic [15:0] cyc;
        logic        aerr;
        logic [7:0]  rdat;
        logic [7:0]  rises;
        logic [3:0]  starts;
        logic [7:0]  abyte;
        logic [7:0]  wbyte;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] slv_rd;
        logic       dnack;
        logic       exp_aerr;
        logic [7:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int base_rise = 0;
    int base_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver: called at a negedge with busy=0; returns one negedge later
    task automatic issue(input logic rw_i, input logic [6:0] a, input logic [7:0] wd);
        req.rw = rw_i; req.addr = a; req.wdata = wd; req.start = 1'b1;
        @(negedge clk);
        req.start = 1'b0;
    endtask

    task automatic start_vec(input vec_t v);
        exp_t e;
        logic absent;
        absent = (v.addr != SLV_ADDR);
        slv_rd_data = v.slv_rd;
        slv_data_nack = v.dnack;
        base_rise = rise_cnt;
        base_start = start_cnt;
        e.aerr  = v.exp_aerr;
        e.rdat  = v.exp_rdata;
        e.abyte = {v.addr, v.rw};
        e.wbyte = (v.rw || absent) ? 8'h00 : v.wdata;
        if (absent) begin
            e.cyc    = 16'((RETRY ? 88 : 44) * CLK_DIV);
            e.rises  = 8'(RETRY ? 20 : 10);
            e.starts = 4'(RETRY ? 2 : 1);
        end else begin
            e.cyc    = 16'(80 * CLK_DIV);
            e.rises  = 8'd19;
            e.starts = 4'd1;
        end
        exp_q.push_back(e);
        issue(v.rw, v.addr, v.wdata);
        check("busy_after_start", req.busy, 1);
        check("ack_err_cleared", req.ack_err, 0);
    endtask

    // Counts busy cycles (first counted cycle is the current one) and compares at done.
    task automatic finish_vec(input vec_t v, input bit poke);
        exp_t e;
        int cyc;
        cyc = 0;
        while (req.busy && cyc < 4000) begin
            cyc = cyc + 1;
            if (poke && cyc == 40) req.start = 1'b1;
            if (poke && cyc == 41) req.start = 1'b0;
            @(negedge clk);
        end
        req.start = 1'b0;
        e = exp_q.pop_front();
        if (cyc >= 4000) begin
            check("timeout_busy", 1, 0);
            return;
        end
        check("busy_cycles", cyc, e.cyc);
        check("done_pulse", req.done, 1);
        check("ack_err", req.ack_err, e.aerr);
        check("rdata", req.rdata, e.rdat);
        check("scl_rises", rise_cnt - base_rise, e.rises);
        check("start_conds", start_cnt - base_start, e.starts);
        check("addr_byte", slv_abyte, e.abyte);
        if (v.addr == SLV_ADDR) check("slave_wbyte", slv_wbyte, e.wbyte);
        if (v.addr == SLV_ADDR && v.rw) check("master_nack_read", slv_mack, 1);
    endtask

    task automatic run_vec(input vec_t v, input bit poke);
        start_vec(v);
        finish_vec(v, poke);
        @(negedge clk);
        check("done_one_cycle", req.done, 0);
        check("idle_after", req.busy, 0);
    endtask

    vec_t vecs[9];
    vec_t va, vb;
    logic [7:0] rnd;

    initial begin
        rnd = 8'($urandom_range(0, 255));
        //          rw    addr   wdata  slv_rd dnack aerr rdata
        vecs[0] = '{1'b0, 7'h27, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'h27, 8'h00, 8'h3C, 1'b0, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 7'h10, 8'hA5, 8'h00, 1'b0, 1'b1, 8'h3C};
        vecs[3] = '{1'b0, 7'h27, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h3C};
        vecs[4] = '{1'b1, 7'h27, 8'h00, 8'hC3, 1'b0, 1'b0, 8'hC3};
        vecs[5] = '{1'b1, 7'h10, 8'h00, 8'h00, 1'b0, 1'b1, 8'hC3};
        vecs[6] = '{1'b0, 7'h27, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hC3};
        vecs[7] = '{1'b0, 7'h27, 8'h00, 8'h00, 1'b0, 1'b0, 8'hC3};
        vecs[8] = '{1'b0, 7'h27, rnd,   8'h00, 1'b0, 1'b0, 8'hC3};

        req.start = 1'b0; req.rw = 1'b0; req.addr = '0; req.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", req.busy, 0);
        check("rst_done", req.done, 0);
        check("rst_ack_err", req.ack_err, 0);
        check("rst_rdata", req.rdata, 8'h00);
        check("rst_scl", scl, 1);
        check("rst_sda", sda_bus, 1);
        check("rst_fsm_idle", fsm_state, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i == 0);

        // start coincident with done: second transaction starts at once
        va = '{1'b0, 7'h27, 8'h96, 8'h00, 1'b0, 1'b0, 8'hC3};
        vb = '{1'b1, 7'h27, 8'h00, 8'h81, 1'b0, 1'b0, 8'h81};
        start_vec(va);
        finish_vec(va, 1'b0);
        start_vec(vb);
        finish_vec(vb, 1'b0);
        @(negedge clk);
        check("b2b_done_one_cycle", req.done, 0);

        // reset during DATA bit 3 (wdata bit 4 is 0, so the master is pulling SDA)
        repeat (2) @(negedge clk);
        slv_data_nack = 1'b0;
        issue(1'b0, 7'h27, 8'hA5);
        repeat (210) @(negedge clk);
        check("pre_reset_sda_low", sda_bus, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda_bus, 1);
        check("mid_rst_busy", req.busy, 0);
        check("mid_rst_done", req.done, 0);
        check("mid_rst_rdata", req.rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        va = '{1'b0, 7'h27, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00};
        run_vec(va, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
